// File: rtl/alu_mul_sequencer_if.sv
// alu_mul_sequencer_if: ALU function codes plus the issue/ALU bundle of the multiply sequencer
// opcodes: ALU function encoding shared with the datapath ALU
// alu_mul_sequencer_if: start/a/b/busy/done/product/overflow toward issue logic,
//   alu_op/alu_op1/alu_op2/alu_result/alu_flags toward the shared ALU
//   slave modport = sequencer side, master modport = issue logic + ALU side
package opcodes;
  typedef enum logic [3:0] {
    FnNOP = 4'd0,
    FnADD = 4'd1,
    FnSUB = 4'd2,
    FnAND = 4'd3,
    FnOR  = 4'd4,
    FnXOR = 4'd5,
    FnLSL = 4'd6,
    FnLSR = 4'd7
  } alu_functions_t;
endpackage

interface alu_mul_sequencer_if;
  import opcodes::*;
  logic           start;
  logic [15:0]    a;
  logic [15:0]    b;
  logic           busy;
  logic           done;
  logic [15:0]    product;
  logic           overflow;
  alu_functions_t alu_op;
  logic [15:0]    alu_op1;
  logic [15:0]    alu_op2;
  logic [15:0]    alu_result;
  logic [3:0]     alu_flags;
  modport slave (
    input  start, a, b, alu_result, alu_flags,
    output busy, done, product, overflow, alu_op, alu_op1, alu_op2
  );
  modport master (
    output start, a, b, alu_result, alu_flags,
    input  busy, done, product, overflow, alu_op, alu_op1, alu_op2
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: 16x16 unsigned shift-and-add multiply sequenced through the shared ALU
// clk/rst: clock, synchronous active-high reset
// bus (slave): start/a/b in, busy/done/product/overflow out; alu_op/alu_op1/alu_op2 out
//   to the ALU, alu_result/alu_flags (bit 1 = carry) back from it in the same cycle
module alu_mul_sequencer
  import opcodes::*;
(
  input logic               clk,
  input logic               rst,
  alu_mul_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;
  state_t      state, nxt;
  logic [15:0] acc, mcand, mplier, m1;
  logic        ovf, flags_unused;
  assign m1 = mplier >> 1;
  assign flags_unused = &{bus.alu_flags[3:2], bus.alu_flags[0]};
  assign bus.alu_op  = state == ADD ? FnADD : state == SHIFT ? FnLSL : FnNOP;
  assign bus.alu_op1 = state == ADD ? acc : state == SHIFT ? mcand : '0;
  assign bus.alu_op2 = state == ADD ? mcand : '0;
  always_comb begin
    nxt = state == IDLE  ? (bus.start ? (bus.b == '0 ? DONE : bus.b[0] ? ADD : SHIFT) : IDLE)
        : state == ADD   ? (m1 == '0 ? DONE : SHIFT)
        : state == SHIFT ? (m1 == '0 ? DONE : m1[0] ? ADD : SHIFT)
        : IDLE;
  end
  // busy/done are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      ovf          <= 1'b0;
      bus.product  <= '0;
      bus.overflow <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      state    <= nxt;
      bus.busy <= nxt != IDLE;
      bus.done <= nxt == DONE;
      case (state)
        IDLE: if (bus.start) begin
          acc    <= '0;
          mcand  <= bus.a;
          mplier <= bus.b;
          ovf    <= 1'b0;
        end
        ADD: begin
          acc <= bus.alu_result;
          ovf <= ovf | bus.alu_flags[1];
        end
        SHIFT: begin
          mcand  <= bus.alu_result;
          mplier <= m1;
          // a multiplicand bit shifted out only matters if a later multiplier bit would add it
          ovf    <= ovf | (mcand[15] & (m1 != '0));
        end
        DONE: begin
          bus.product  <= acc;
          bus.overflow <= ovf;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: directed scoreboard bench for alu_mul_sequencer with a behavioural ALU
module tb_alu_mul_sequencer;
  import opcodes::*;
  typedef struct {
    logic [15:0] p;
    logic        o;
    int          lat;
    int          adds;
    int          shifts;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  alu_mul_sequencer_if bus();
  alu_mul_sequencer dut(.clk(clk), .rst(rst), .bus(bus.slave));
  logic [16:0] sum;
  assign sum = {1'b0, bus.alu_op1} + {1'b0, bus.alu_op2};
  assign bus.alu_result = bus.alu_op == FnADD ? sum[15:0] : bus.alu_op == FnLSL ? {bus.alu_op1[14:0], 1'b0} : '0;
  assign bus.alu_flags = {2'b00, bus.alu_op == FnADD && sum[16], 1'b0};
  exp_t sb[$];
  int vecs = 0;
  int errs = 0;
  logic [31:0] tr;
  logic [15:0] want_seq;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [15:0] av, input logic [15:0] bv, input bit hold, output logic [31:0] trace);
    exp_t e;
    int cyc, adds, shifts, h, p;
    logic [31:0] full;
    full = {16'b0, av} * {16'b0, bv};
    h = 0;
    p = 0;
    for (int i = 0; i < 16; i++) if (bv[i]) begin p++; h = i; end
    e.p = full[15:0];
    e.o = full[31:16] != 0;
    e.lat = bv == 0 ? 1 : 1 + h + p;
    e.adds = p;
    e.shifts = bv == 0 ? 0 : h;
    sb.push_back(e);
    @(negedge clk);
    bus.a = av;
    bus.b = bv;
    bus.start = 1;
    @(negedge clk);
    cyc = 1;
    if (!hold) bus.start = 0;
    bus.a = ~av;
    bus.b = ~bv;
    chk("busy_rise", bus.busy, 1);
    adds = 0;
    shifts = 0;
    trace = 0;
    while (!bus.done && cyc < 40) begin
      if (bus.alu_op == FnADD) adds++;
      if (bus.alu_op == FnLSL) shifts++;
      trace = {trace[27:0], bus.alu_op};
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    chk("done_seen", bus.done, 1);
    chk("latency", cyc, e.lat);
    chk("busy_at_done", bus.busy, 1);
    chk("alu_op_at_done", bus.alu_op, FnNOP);
    chk("add_count", adds, e.adds);
    chk("lsl_count", shifts, e.shifts);
    @(negedge clk);
    bus.start = 0;
    chk("busy_after", bus.busy, 0);
    chk("done_pulse", bus.done, 0);
    chk("product", bus.product, e.p);
    chk("overflow", bus.overflow, e.o);
  endtask
  initial begin
    bus.start = 0;
    bus.a = 0;
    bus.b = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_product", bus.product, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_alu_op", bus.alu_op, FnNOP);
    chk("rst_op1", bus.alu_op1, 0);
    chk("rst_op2", bus.alu_op2, 0);
    rst = 0;
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("idle_alu_op", bus.alu_op, FnNOP);
    run(16'd3, 16'd5, 0, tr);
    want_seq = {4'(FnADD), 4'(FnLSL), 4'(FnLSL), 4'(FnADD)};
    chk("seq_3x5", tr[15:0], want_seq);
    run(16'h1234, 16'h0000, 0, tr);
    run(16'h8000, 16'h0002, 0, tr);
    run(16'd255, 16'd257, 0, tr);
    run(16'd256, 16'd256, 0, tr);
    run(16'h0101, 16'h00ff, 0, tr);
    run(16'hffff, 16'hffff, 1, tr);
    @(negedge clk);
    bus.a = 7;
    bus.b = 9;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_product", bus.product, 0);
    chk("midrst_overflow", bus.overflow, 0);
    chk("midrst_alu_op", bus.alu_op, FnNOP);
    rst = 0;
    @(negedge clk);
    chk("postrst_done", bus.done, 0);
    chk("postrst_busy", bus.busy, 0);
    run(16'd7, 16'd9, 0, tr);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle controller that computes an unsigned 16x16 multiply (low 16 bits plus overflow) by sequencing the shared 16-bit ALU through shift-and-add steps. It sits beside the ALU in the datapath and drives the ALU's `AluOp`/`Op1`/`Op2` inputs while busy. It issues only the existing `FnADD`, `FnLSL` and `FnNOP` functions, so no new ALU hardware is needed. Issue logic sees a simple Start/Busy/Done handshake.

## Interface
Parameters: none (width fixed at 16 to match the ALU).

- `Clock` input 1: single clock; all state changes on rising edge.
- `Reset` input 1: synchronous, active-high.
- `Start` input 1: request; sampled only in IDLE.
- `A` input 16: multiplicand; captured on accepted Start.
- `B` input 16: multiplier; captured on accepted Start.
- `Busy` output 1: high in every non-IDLE state.
- `Done` output 1: one-cycle pulse, high in DONE state.
- `Product` output 16: low 16 bits of A*B; holds until next accepted Start.
- `Overflow` output 1: high if the true product is at least 2^16; holds with `Product`.
- `AluOp` output `opcodes::alu_functions_t`: function driven to the ALU.
- `AluOp1` output 16: to ALU `Op1`.
- `AluOp2` output 16: to ALU `Op2`.
- `AluResult` input 16: from ALU `Result`.
- `AluFlags` input 4: from ALU `Flags`. Bit 1 = carry; other bits unused.

## Operation
- Internal registers: `Acc`, `Mcand`, `Mplier` (each 16 bits), `Ovf` (1 bit), plus the state.
- States: IDLE, ADD, SHIFT, DONE.
- **IDLE**
  - ALU outputs: `AluOp=FnNOP`, `AluOp1=AluOp2=0`.
  - On `Start`: `Acc<=0`, `Mcand<=A`, `Mplier<=B`, `Ovf<=0`.
  - Next state: DONE if B==0; else ADD if B[0]; else SHIFT.
- **ADD**
  - ALU outputs: `AluOp=FnADD`, `AluOp1=Acc`, `AluOp2=Mcand`.
  - Updates: `Acc<=AluResult`; `Ovf<=Ovf|AluFlags[1]`.
  - Next state: DONE if (Mplier>>1)==0; else SHIFT.
- **SHIFT**
  - ALU outputs: `AluOp=FnLSL`, `AluOp1=Mcand`, `AluOp2=0`.
  - Updates: `Mcand<=AluResult`; `Mplier<=Mplier>>1`.
  - Overflow: `Ovf<=Ovf|(Mcand[15] & ((Mplier>>1)!=0))`. A bit lost from Mcand that is later added counts as overflow.
  - Next state, using the shifted multiplier M' = Mplier>>1: DONE if M'==0; else ADD if M'[0]; else SHIFT.
- **DONE**
  - `Done=1`; `Product<=Acc`; `Overflow<=Ovf`.
  - ALU outputs as in IDLE.
  - Next state: IDLE unconditionally.
- The ALU outputs are combinational from the state and registers. The ALU result is consumed in the same cycle.
- `Start` outside IDLE is ignored; it is not queued. `A`/`B` changes after capture have no effect.
- Arithmetic is modulo 2^16. `Overflow` is exact for unsigned operands.
- Reset, in any state including mid-operation:
  - State goes to IDLE.
  - `Acc`, `Mcand`, `Mplier`, `Ovf`, `Product` <= 0; `Overflow`, `Done`, `Busy` <= 0.
  - `AluOp=FnNOP`.

## Timing
- Cycle 0 is the edge where `Start` is sampled in IDLE.
- Latency:
  - B==0: `Done` is high in cycle 1.
  - Otherwise: `Done` is high in cycle 1 + h + p, where h = index of the highest set bit of B and p = popcount(B).
  - Maximum latency is 32 cycles (B=0xFFFF).
- `Busy` rises in cycle 1 and is high through the `Done` cycle. It is low in the cycle after `Done`.
- `Product`/`Overflow` become valid in the cycle after `Done`, and remain stable until the next accepted Start plus that operation's `Done`.
- The earliest back-to-back Start is sampled in the cycle after `Done`.
- No ALU ownership handshake is provided. The external mux selects this block's ALU outputs while `Busy` is high.

## Test plan
- Reset, then idle: all outputs 0, `AluOp=FnNOP`, `Busy=0`.
- A=3, B=5, Start pulse:
  - `AluOp` sequence ADD, LSL, LSL, ADD, then `Done` in cycle 5.
  - `Product=15`, `Overflow=0`.
- A=0x1234, B=0: `Done` in cycle 1, `Product=0`, `Overflow=0`, no ADD/LSL issued.
- A=0x8000, B=2: `Product=0x0000`, `Overflow=1`.
- A=0xFFFF, B=0xFFFF:
  - `Done` in cycle 32, `Product=0x0001`, `Overflow=1`.
  - `Start` held high throughout is ignored until IDLE.
- Start A=7, B=9; assert `Reset` in cycle 3:
  - Next cycle: `Busy=0`, `Product=0`, no `Done` pulse.
  - A new Start with A=7, B=9 then gives `Product=63`.
